// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one cache port among NREQ requesters, with issue/complete sequencing and timeout
module cache_port_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 32,
   parameter int DW      = 8,
   parameter int OPW     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic [NREQ-1:0]     req_valid_i,
   input  logic [NREQ*OPW-1:0] req_op_i,
   input  logic [NREQ*AW-1:0]  req_addr_i,
   input  logic [NREQ*DW-1:0]  req_wdata_i,
   output logic [NREQ-1:0]     req_grant_o,
   output logic [NREQ-1:0]     req_done_o,
   output logic [DW-1:0]       rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                c_valid_o,
   output logic [OPW-1:0]      c_op_o,
   output logic [AW-1:0]       c_addr_o,
   output logic [DW-1:0]       c_wdata_o,
   input  logic                c_ready_i,
   input  logic                c_done_i,
   input  logic [DW-1:0]       c_rdata_i,
   output logic                busy_o
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d, owner_q, owner_d, win;
   logic            win_vld;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   data_q, data_d;
   logic            err_q, err_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            take, active, tmo, done_evt, tmo_evt;

   // first valid requester at or after rr_q; the lowest offset is written last and wins
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid_i[(int'(rr_q) + k) % NREQ]) begin
            win     = IW'((int'(rr_q) + k) % NREQ);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      take     = state_q == IDLE && win_vld;
      active   = state_q == ISSUE || state_q == WAIT;
      tmo      = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
      done_evt = (state_q == ISSUE && c_ready_i && c_done_i) || (state_q == WAIT && c_done_i);
      tmo_evt  = active && tmo && !done_evt;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = take ? ISSUE : IDLE;
         ISSUE:   state_d = (done_evt || tmo_evt) ? RESP : c_ready_i ? WAIT : ISSUE;
         WAIT:    state_d = (done_evt || tmo_evt) ? RESP : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      owner_d = take ? win : owner_q;
      op_d    = take ? req_op_i[int'(win)*OPW +: OPW] : op_q;
      addr_d  = take ? req_addr_i[int'(win)*AW +: AW] : addr_q;
      wdata_d = take ? req_wdata_i[int'(win)*DW +: DW] : wdata_q;
      grant_d = take ? ONE << win : '0;
      cnt_d   = active ? cnt_q + 1'b1 : '0;
      data_d  = done_evt ? c_rdata_i : tmo_evt ? '0 : data_q;
      err_d   = done_evt ? 1'b0 : tmo_evt ? 1'b1 : err_q;
      rr_d    = (state_q == RESP) ? ((owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1) : rr_q;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         grant_q <= '0;
      end else begin
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      busy_o      = state_q != IDLE;
      c_valid_o   = state_q == ISSUE;
      req_done_o  = (state_q == RESP) ? ONE << owner_q : '0;
      rsp_err_o   = state_q == RESP && err_q;
      rsp_rdata_o = data_q;
      req_grant_o = grant_q;
      c_op_o      = op_q;
      c_addr_o    = addr_q;
      c_wdata_o   = wdata_q;
   end
endmodule
